sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Arbitrates and sequences access to the single-port sdram controller's byte interface (addr/din/we/oe/dout, clocked against F14M) between three requesters: ROM/image download (data_io), video fetch, and the Z80 CPU. It runs one access at a time as a fixed-length slot, drives the controller's we/oe strobes for that slot, captures read data and returns a one-cycle ack to the granted requester. It also generates the CPU WAIT_n line.

Parameters:
ACC_CYCLES, 4, F14M cycles sd_we/sd_oe are held per access; sd_dout valid in the last of them; legal range 2..15.
STARVE_MAX, 3, consecutive grants to higher-priority requesters while cpu_req is pending before the CPU is forced to win; range 1..15.

Ports:
F14M  in  1  system clock; all logic on rising edge.
RESET  in  1  asynchronous, active-high reset.
dl_req  in  1  download write request (level, held until dl_ack).
dl_addr  in  25  download byte address.
dl_din  in  8  download write data.
dl_ack  out  1  one-cycle pulse: download write complete.
vid_req  in  1  video read request (level, held until vid_ack).
vid_addr  in  25  video byte address.
vid_dout  out  8  video read data, valid with vid_ack and held until next video ack.
vid_ack  out  1  one-cycle pulse: video read complete.
cpu_req  in  1  CPU access request (level, held until cpu_ack).
cpu_we  in  1  1 = write, 0 = read; sampled at grant.
cpu_addr  in  25  CPU byte address (already paged).
cpu_din  in  8  CPU write data.
cpu_dout  out  8  CPU read data, valid with cpu_ack and held until next CPU ack.
cpu_ack  out  1  one-cycle pulse: CPU access complete.
cpu_wait_n  out  1  Z80 WAIT_n; 0 while a CPU request is outstanding.
sd_addr  out  25  to sdram addr.
sd_din  out  8  to sdram din.
sd_we  out  1  to sdram we.
sd_oe  out  1  to sdram oe.
sd_dout  in  8  from sdram dout.

Behaviour:
- Reset (async, immediate): state IDLE; sd_we=sd_oe=0; sd_addr=0; sd_din=0; all acks 0; vid_dout=cpu_dout=0; starve counter 0; cpu_wait_n=1.
- States: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE: if any request is pending, latch the winner's id, addr, din and direction. Drive sd_addr/sd_din and assert sd_we (download, CPU write) or sd_oe (video, CPU read) starting the next cycle. Go to ACCESS with slot counter = ACC_CYCLES-1.
- Priority: dl > vid > cpu. Exception: starve counter == STARVE_MAX and cpu_req=1 -> CPU wins.
- Starve counter: +1 (saturating) on each grant to dl or vid while cpu_req=1; cleared on CPU grant or when cpu_req=0.
- ACCESS: counter decrements each cycle. sd_addr/sd_din/strobe are held stable for exactly ACC_CYCLES cycles. On the last cycle (counter=0), capture sd_dout into vid_dout or cpu_dout (reads only), then go to ACK.
- ACK: strobes deasserted; the granted ack pulses for exactly 1 cycle; go to IDLE.
- Requests are not re-evaluated in ACK. Back-to-back access period = ACC_CYCLES+2 cycles.
- Requester must drop req the cycle after its ack, or keep it high to issue a new access. A req still high in the cycle after ack is treated as a new request.
- Changes to a requester's addr/din/we after grant are ignored; values are latched at grant.
- Request withdrawn before grant: not serviced, no ack. Withdrawn after grant: access completes and ack is still pulsed.
- cpu_wait_n = ~(cpu_req & ~cpu_ack), combinational. Deasserts in the ack cycle so the Z80 completes the cycle with cpu_dout valid.
- Never more than one of sd_we/sd_oe asserted. Never more than one ack per cycle.
- RESET asserted mid-access: strobes drop at once, no ack is issued, and the pending access is lost.

Test Plan:
- Reset mid-access: assert RESET during the 2nd ACCESS cycle of a vid read -> sd_oe=0 immediately, no vid_ack, all outputs at reset values; after release, IDLE with cpu_wait_n=1.
- Single CPU read, ACC_CYCLES=4: cpu_req=1, cpu_we=0, cpu_addr=0x1C3801, sdram model returns 0x42 -> sd_oe high exactly 4 cycles with sd_addr=0x1C3801; cpu_ack pulses 1 cycle later with cpu_dout=0x42; cpu_wait_n low from cpu_req until the ack cycle.
- Download write: dl_req=1, dl_addr=0x000005, dl_din=0xF3 -> sd_we high 4 cycles with sd_din=0xF3; dl_ack 1 cycle; sd_oe stays 0 throughout.
- Simultaneous requests: dl, vid and cpu all raised in the same cycle, each dropped after its own ack -> grant order dl, vid, cpu; acks 6 cycles apart; no overlapping strobes.
- Starvation guard, STARVE_MAX=3: vid_req held high continuously and cpu_req held -> exactly 3 vid grants, then a CPU grant, then vid resumes.
- Mid-access input change: change cpu_addr and cpu_din during ACCESS -> sd_addr and sd_din unchanged until the ack.

Source files
------------

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_arbiter : fixed-slot arbiter of download / video / Z80 onto the sdram
//                 byte port, with CPU starvation guard and Z80 WAIT_n
// Revision      : 1.0
// ============================================================================
module sdram_arbiter #(
  parameter int ACC_CYCLES = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        F14M,
  input  logic        RESET,

  input  logic        dl_req,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_din,
  output logic        dl_ack,

  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic [7:0]  vid_dout,
  output logic        vid_ack,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait_n,

  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  output logic        sd_we,
  output logic        sd_oe,
  input  logic [7:0]  sd_dout
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic [1:0] GNT_DL  = 2'd0;
  localparam logic [1:0] GNT_VID = 2'd1;
  localparam logic [1:0] GNT_CPU = 2'd2;

  localparam logic [3:0] CNT_INIT   = 4'(ACC_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  vid_dout_q, vid_dout_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic [3:0]  starve_q, starve_d;

  logic        grant_vld;
  logic [1:0]  grant_id;
  logic        grant_wr;
  logic [24:0] grant_addr;
  logic [7:0]  grant_din;
  logic        cpu_forced;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= GNT_DL;
      wr_q       <= 1'b0;
      addr_q     <= 25'd0;
      din_q      <= 8'd0;
      vid_dout_q <= 8'd0;
      cpu_dout_q <= 8'd0;
      starve_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      vid_dout_q <= vid_dout_d;
      cpu_dout_q <= cpu_dout_d;
      starve_q   <= starve_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection: dl > vid > cpu, unless the CPU has been passed over
  // STARVE_MAX times in a row.
  // ---------------------------------------------------------------------------
  assign cpu_forced = cpu_req && (starve_q == STARVE_LIM);

  always_comb begin
    grant_vld  = 1'b1;
    grant_id   = GNT_DL;
    grant_wr   = 1'b1;
    grant_addr = dl_addr;
    grant_din  = dl_din;
    if (cpu_forced) begin
      grant_id   = GNT_CPU;
      grant_wr   = cpu_we;
      grant_addr = cpu_addr;
      grant_din  = cpu_din;
    end else if (dl_req) begin
      grant_id   = GNT_DL;
    end else if (vid_req) begin
      grant_id   = GNT_VID;
      grant_wr   = 1'b0;
      grant_addr = vid_addr;
      grant_din  = 8'd0;
    end else if (cpu_req) begin
      grant_id   = GNT_CPU;
      grant_wr   = cpu_we;
      grant_addr = cpu_addr;
      grant_din  = cpu_din;
    end else begin
      grant_vld  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    vid_dout_d = vid_dout_q;
    cpu_dout_d = cpu_dout_q;
    starve_d   = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_INIT;
          gnt_d   = grant_id;
          wr_d    = grant_wr;
          addr_d  = grant_addr;
          din_d   = grant_din;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          if (!wr_q) begin
            if (gnt_q == GNT_VID) vid_dout_d = sd_dout;
            if (gnt_q == GNT_CPU) cpu_dout_d = sd_dout;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only counts while the CPU is actually waiting; any CPU win resets it.
    if (!cpu_req) begin
      starve_d = 4'd0;
    end else if ((state_q == ST_IDLE) && grant_vld) begin
      if (grant_id == GNT_CPU) begin
        starve_d = 4'd0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    sd_addr    = addr_q;
    sd_din     = din_q;
    sd_we      = (state_q == ST_ACCESS) &&  wr_q;
    sd_oe      = (state_q == ST_ACCESS) && !wr_q;
    dl_ack     = (state_q == ST_ACK) && (gnt_q == GNT_DL);
    vid_ack    = (state_q == ST_ACK) && (gnt_q == GNT_VID);
    cpu_ack    = (state_q == ST_ACK) && (gnt_q == GNT_CPU);
    vid_dout   = vid_dout_q;
    cpu_dout   = cpu_dout_q;
    cpu_wait_n = ~(cpu_req & ~((state_q == ST_ACK) && (gnt_q == GNT_CPU)));
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_arbiter : directed self-checking bench for sdram_arbiter
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_arbiter;

  logic        clk;
  logic        rst;
  logic        dl_req;
  logic [24:0] dl_addr;
  logic [7:0]  dl_din;
  logic        dl_ack;
  logic        vid_req;
  logic [24:0] vid_addr;
  logic [7:0]  vid_dout;
  logic        vid_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_wait_n;
  logic [24:0] sd_addr;
  logic [7:0]  sd_din;
  logic        sd_we;
  logic        sd_oe;
  logic [7:0]  sd_dout;

  int checks;
  int failures;
  int excl_err;
  int vid_ack_cnt;

  sdram_arbiter #(.ACC_CYCLES(4), .STARVE_MAX(3)) dut (
    .F14M(clk), .RESET(rst),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sdram read model: data = low address byte XOR 0x43
  assign sd_dout = sd_oe ? (sd_addr[7:0] ^ 8'h43) : 8'h00;

  always @(negedge clk) begin
    if ((sd_we && sd_oe) || (int'(dl_ack) + int'(vid_ack) + int'(cpu_ack) > 1))
      excl_err <= excl_err + 1;
    if (vid_ack) vid_ack_cnt <= vid_ack_cnt + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sd_we !== 1'b0 || sd_oe !== 1'b0) begin failures++;
      $display("FAIL reset_strobes we=%b oe=%b expected 0 0", sd_we, sd_oe); end
    checks++; if (sd_addr !== 25'd0 || sd_din !== 8'd0) begin failures++;
      $display("FAIL reset_bus addr=%h din=%h expected 0 0", sd_addr, sd_din); end
    checks++; if ({dl_ack, vid_ack, cpu_ack} !== 3'b000) begin failures++;
      $display("FAIL reset_acks got=%b expected 000", {dl_ack, vid_ack, cpu_ack}); end
    checks++; if (vid_dout !== 8'd0 || cpu_dout !== 8'd0 || cpu_wait_n !== 1'b1) begin failures++;
      $display("FAIL reset_out vid_dout=%h cpu_dout=%h wait_n=%b expected 00 00 1",
               vid_dout, cpu_dout, cpu_wait_n); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int acks0;
    vid_addr = 25'h000077;
    vid_req  = 1'b1;
    @(negedge clk);
    checks++; if (sd_oe !== 1'b1) begin failures++;
      $display("FAIL rma_oe_cycle1 got=%b expected 1", sd_oe); end
    @(negedge clk);
    acks0 = vid_ack_cnt;
    #1 rst = 1'b1;
    #1;
    checks++; if (sd_oe !== 1'b0 || sd_addr !== 25'd0 || vid_ack !== 1'b0) begin failures++;
      $display("FAIL rma_async oe=%b addr=%h ack=%b expected 0 0 0", sd_oe, sd_addr, vid_ack); end
    vid_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (vid_ack_cnt !== acks0) begin failures++;
      $display("FAIL rma_no_ack acks=%0d expected %0d", vid_ack_cnt, acks0); end
    checks++; if (cpu_wait_n !== 1'b1 || sd_oe !== 1'b0 || sd_we !== 1'b0 || vid_dout !== 8'd0) begin failures++;
      $display("FAIL rma_idle wait_n=%b oe=%b we=%b vid_dout=%h expected 1 0 0 00",
               cpu_wait_n, sd_oe, sd_we, vid_dout); end
  endtask

  task automatic test_cpu_read();
    int oe_cnt = 0, addr_err = 0, wait_err = 0, ack_at = -1;
    cpu_we   = 1'b0;
    cpu_addr = 25'h1C3801;
    cpu_req  = 1'b1;
    #1;
    checks++; if (cpu_wait_n !== 1'b0) begin failures++;
      $display("FAIL cpu_rd_wait_start got=%b expected 0", cpu_wait_n); end
    for (int i = 1; i <= 12 && ack_at < 0; i++) begin
      @(negedge clk);
      if (sd_oe) begin oe_cnt++; if (sd_addr !== 25'h1C3801) addr_err++; end
      if (cpu_ack) begin
        ack_at = i;
        checks++; if (cpu_dout !== 8'h42 || cpu_wait_n !== 1'b1) begin failures++;
          $display("FAIL cpu_rd_data dout=%h wait_n=%b expected 42 1", cpu_dout, cpu_wait_n); end
        cpu_req = 1'b0;
      end else if (cpu_wait_n !== 1'b0) wait_err++;
    end
    checks++; if (oe_cnt != 4 || addr_err != 0) begin failures++;
      $display("FAIL cpu_rd_oe cycles=%0d addr_err=%0d expected 4 0", oe_cnt, addr_err); end
    checks++; if (ack_at != 5 || wait_err != 0) begin failures++;
      $display("FAIL cpu_rd_ack at=%0d wait_err=%0d expected 5 0", ack_at, wait_err); end
    @(negedge clk);
    checks++; if (cpu_ack !== 1'b0 || cpu_dout !== 8'h42) begin failures++;
      $display("FAIL cpu_rd_pulse ack=%b dout=%h expected 0 42", cpu_ack, cpu_dout); end
  endtask

  task automatic test_dl_write();
    int we_cnt = 0, din_err = 0, oe_seen = 0, ack_at = -1;
    dl_addr = 25'h000005;
    dl_din  = 8'hF3;
    dl_req  = 1'b1;
    for (int i = 1; i <= 12 && ack_at < 0; i++) begin
      @(negedge clk);
      if (sd_oe) oe_seen++;
      if (sd_we) begin we_cnt++; if (sd_din !== 8'hF3 || sd_addr !== 25'h5) din_err++; end
      if (dl_ack) begin ack_at = i; dl_req = 1'b0; end
    end
    checks++; if (we_cnt != 4 || din_err != 0 || oe_seen != 0) begin failures++;
      $display("FAIL dl_wr_we cycles=%0d din_err=%0d oe=%0d expected 4 0 0", we_cnt, din_err, oe_seen); end
    checks++; if (ack_at != 5) begin failures++;
      $display("FAIL dl_wr_ack at=%0d expected 5", ack_at); end
    @(negedge clk);
    checks++; if (dl_ack !== 1'b0) begin failures++;
      $display("FAIL dl_wr_pulse ack=%b expected 0", dl_ack); end
  endtask

  task automatic test_simultaneous();
    int dl_at = -1, vid_at = -1, cpu_at = -1;
    logic [7:0] vd = 8'h00, cd = 8'h00;
    vid_addr = 25'h000010;
    cpu_addr = 25'h000020;
    cpu_we   = 1'b0;
    dl_addr  = 25'h000001;
    dl_din   = 8'h11;
    dl_req = 1'b1; vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dl_ack)  begin dl_at = i;  dl_req = 1'b0; end
      if (vid_ack) begin vid_at = i; vd = vid_dout; vid_req = 1'b0; end
      if (cpu_ack) begin cpu_at = i; cd = cpu_dout; cpu_req = 1'b0; end
    end
    checks++; if (dl_at != 5 || vid_at != 11 || cpu_at != 17) begin failures++;
      $display("FAIL simul_order dl=%0d vid=%0d cpu=%0d expected 5 11 17", dl_at, vid_at, cpu_at); end
    checks++; if (vd !== 8'h53 || cd !== 8'h63) begin failures++;
      $display("FAIL simul_data vid=%h cpu=%h expected 53 63", vd, cd); end
  endtask

  task automatic test_back_to_back();
    int seq [5];
    int at  [5];
    int n = 0;
    vid_addr = 25'h000030;
    cpu_addr = 25'h000040;
    cpu_we   = 1'b0;
    vid_req  = 1'b1;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 60 && n < 5; i++) begin
      @(negedge clk);
      if (vid_ack) begin seq[n] = 1; at[n] = i; n++; end
      else if (cpu_ack) begin seq[n] = 2; at[n] = i; n++; cpu_req = 1'b0; end
      if (n == 5) vid_req = 1'b0;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    checks++; if (n != 5) begin failures++;
      $display("FAIL starve_count acks=%0d expected 5", n); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (n == 5 && seq[k] != ((k == 3) ? 2 : 1)) begin failures++;
        $display("FAIL starve_seq[%0d] got=%0d expected %0d", k, seq[k], (k == 3) ? 2 : 1); end
    end
    checks++; if (n == 5 && (at[1] - at[0] != 6 || at[4] - at[3] != 6)) begin failures++;
      $display("FAIL b2b_period got=%0d,%0d expected 6,6", at[1] - at[0], at[4] - at[3]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_change();
    int we_cnt = 0, bus_err = 0, ack_at = -1;
    cpu_we   = 1'b1;
    cpu_addr = 25'h0ABCDE;
    cpu_din  = 8'h3C;
    cpu_req  = 1'b1;
    for (int i = 1; i <= 12 && ack_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) begin cpu_addr = 25'h1FFFFFF; cpu_din = 8'hFF; cpu_we = 1'b0; end
      if (sd_oe) bus_err++;
      if (sd_we) begin we_cnt++; if (sd_addr !== 25'h0ABCDE || sd_din !== 8'h3C) bus_err++; end
      if (cpu_ack) begin
        ack_at = i;
        checks++; if (sd_addr !== 25'h0ABCDE || sd_din !== 8'h3C) begin failures++;
          $display("FAIL midchg_at_ack addr=%h din=%h expected 0abcde 3c", sd_addr, sd_din); end
        cpu_req = 1'b0;
      end
    end
    checks++; if (we_cnt != 4 || bus_err != 0 || ack_at != 5) begin failures++;
      $display("FAIL midchg_hold we=%0d err=%0d ack_at=%0d expected 4 0 5", we_cnt, bus_err, ack_at); end
  endtask

  task automatic test_exclusive();
    checks++; if (excl_err != 0) begin failures++;
      $display("FAIL exclusive_strobes_acks violations=%0d expected 0", excl_err); end
  endtask

  initial begin
    checks = 0; failures = 0; excl_err = 0; vid_ack_cnt = 0;
    rst = 1'b1;
    dl_req = 1'b0; dl_addr = '0; dl_din = '0;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    test_reset();
    test_reset_mid_access();
    test_cpu_read();
    test_dl_write();
    test_simultaneous();
    test_back_to_back();
    test_mid_change();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
